// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - packs 32-bit pixels into 256-bit words and writes frames into a ring of DDR slots
module frame_writer #(
    parameter logic [29:0] BUF_BASE   = 30'h0000000,
    parameter logic [29:0] BUF_STRIDE = 30'h0800000,
    parameter int          NUM_BUFS   = 3,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_clk,
    input  logic         frame_start,
    input  logic         frame_end,
    input  logic         pix_valid,
    input  logic [31:0]  pix_data,
    input  logic         rd_busy,
    input  logic [1:0]   rd_slot,
    output logic         mem_wr_req,
    output logic [28:0]  mem_wr_addr,
    output logic [255:0] mem_wr_data,
    input  logic         mem_wr_ack,
    output logic         frame_ready,
    output logic         frame_drop,
    output logic [29:0]  frame_addr,
    output logic [23:0]  frame_count,
    output logic [1:0]   frame_slot,
    output logic         overflow
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_FLUSH   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [18:0] MAX_WORDS = 19'(BUF_STRIDE >> 5);

    logic [1:0]       state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [1:0]       last_slot_q, last_slot_d;
    logic [255:0]     pack_q, pack_d;
    logic [2:0]       idx_q, idx_d;
    logic [18:0]      push_cnt_q, push_cnt_d;
    logic             bad_q, bad_d;
    logic [18:0]      wr_cnt_q, wr_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             req_q, req_d;
    logic [255:0]     data_q, data_d;
    logic             overflow_q, overflow_d;
    logic             frame_ready_q, frame_ready_d;
    logic             frame_drop_q, frame_drop_d;
    logic [29:0]      frame_addr_q, frame_addr_d;
    logic [23:0]      frame_count_q, frame_count_d;
    logic [1:0]       frame_slot_q, frame_slot_d;

    logic [255:0]     fifo_mem [FIFO_DEPTH];
    logic [255:0]     pack_w;
    logic [255:0]     push_data;
    logic [2:0]       idx_w;
    logic [1:0]       cand;
    logic             push;
    logic             push_ok;
    logic             pop;
    logic             full;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic [29:0]      slot_base;

    function automatic logic [1:0] next_slot(input logic [1:0] s);
        return (s == 2'(NUM_BUFS - 1)) ? 2'd0 : s + 2'd1;
    endfunction

    assign slot_base = BUF_BASE + 30'(slot_q) * BUF_STRIDE;
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign rd_ptr_nx = rd_ptr_q + 1'b1;
    assign pop       = req_q & mem_wr_ack;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        last_slot_d   = last_slot_q;
        pack_d        = pack_q;
        idx_d         = idx_q;
        push_cnt_d    = push_cnt_q;
        bad_d         = bad_q;
        wr_cnt_d      = wr_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        req_d         = req_q;
        data_d        = data_q;
        overflow_d    = overflow_q;
        frame_ready_d = 1'b0;
        frame_drop_d  = 1'b0;
        frame_addr_d  = frame_addr_q;
        frame_count_d = frame_count_q;
        frame_slot_d  = frame_slot_q;
        pack_w        = pack_q;
        idx_w         = idx_q;
        cand          = next_slot(last_slot_q);
        push          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    if (rd_busy && cand == rd_slot) begin
                        cand = next_slot(cand);
                    end
                    slot_d     = cand;
                    wr_cnt_d   = '0;
                    push_cnt_d = '0;
                    idx_d      = '0;
                    pack_d     = '0;
                    bad_d      = 1'b0;
                    state_d    = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (pix_valid) begin
                    pack_w[{idx_q, 5'b0} +: 32] = pix_data;
                    idx_w = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        push = 1'b1;
                    end
                end
                // A pixel arriving with frame_end is packed before the residue is flushed.
                if (frame_end) begin
                    state_d = S_FLUSH;
                    if (idx_w != 3'd0) begin
                        push = 1'b1;
                    end
                end
                if (push) begin
                    pack_d = '0;
                    idx_d  = '0;
                end else begin
                    pack_d = pack_w;
                    idx_d  = idx_w;
                end
            end
            S_FLUSH: begin
                if (count_q == '0 && !req_q) begin
                    state_d       = S_DONE;
                    frame_ready_d = ~bad_q;
                    frame_drop_d  = bad_q;
                    frame_addr_d  = slot_base;
                    frame_count_d = {wr_cnt_q, 5'b0};
                    frame_slot_d  = slot_q;
                    last_slot_d   = slot_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        push_data = pack_w;
        push_ok   = push && !full && (push_cnt_q != MAX_WORDS);
        if (push && !push_ok) begin
            bad_d      = 1'b1;
            overflow_d = 1'b1;
        end
        if (push_ok) begin
            push_cnt_d = push_cnt_q + 19'd1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
        end

        // The presented word stays in the FIFO until acked, so the FIFO holds the full depth.
        if (pop) begin
            wr_cnt_d = wr_cnt_q + 19'd1;
            rd_ptr_d = rd_ptr_nx;
            if (count_q > CNT_W'(1)) begin
                data_d = fifo_mem[rd_ptr_nx];
                req_d  = 1'b1;
            end else if (push_ok) begin
                data_d = push_data;
                req_d  = 1'b1;
            end else begin
                req_d  = 1'b0;
            end
        end else if (!req_q && count_q != '0) begin
            data_d = fifo_mem[rd_ptr_q];
            req_d  = 1'b1;
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset_clk) begin
        if (reset_clk) begin
            state_q       <= S_IDLE;
            slot_q        <= '0;
            last_slot_q   <= 2'(NUM_BUFS - 1);
            pack_q        <= '0;
            idx_q         <= '0;
            push_cnt_q    <= '0;
            bad_q         <= 1'b0;
            wr_cnt_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            req_q         <= 1'b0;
            data_q        <= '0;
            overflow_q    <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_drop_q  <= 1'b0;
            frame_addr_q  <= '0;
            frame_count_q <= '0;
            frame_slot_q  <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            last_slot_q   <= last_slot_d;
            pack_q        <= pack_d;
            idx_q         <= idx_d;
            push_cnt_q    <= push_cnt_d;
            bad_q         <= bad_d;
            wr_cnt_q      <= wr_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            req_q         <= req_d;
            data_q        <= data_d;
            overflow_q    <= overflow_d;
            frame_ready_q <= frame_ready_d;
            frame_drop_q  <= frame_drop_d;
            frame_addr_q  <= frame_addr_d;
            frame_count_q <= frame_count_d;
            frame_slot_q  <= frame_slot_d;
        end
    end

    assign mem_wr_req  = req_q;
    assign mem_wr_addr = slot_base[29:1] + {7'b0, wr_cnt_q, 3'b0};
    assign mem_wr_data = data_q;
    assign frame_ready = frame_ready_q;
    assign frame_drop  = frame_drop_q;
    assign frame_addr  = frame_addr_q;
    assign frame_count = frame_count_q;
    assign frame_slot  = frame_slot_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - scoreboard bench for frame_writer with a frame-level reference model
module tb_frame_writer;

    localparam logic [29:0] BASE   = 30'h0000000;
    localparam logic [29:0] STRIDE = 30'h0800000;
    localparam int          NB     = 3;
    localparam int          DEPTH  = 16;

    logic         clk = 1'b0;
    logic         reset_clk = 1'b1;
    logic         frame_start = 1'b0;
    logic         frame_end = 1'b0;
    logic         pix_valid = 1'b0;
    logic [31:0]  pix_data = '0;
    logic         rd_busy = 1'b0;
    logic [1:0]   rd_slot = '0;
    logic         mem_wr_req;
    logic [28:0]  mem_wr_addr;
    logic [255:0] mem_wr_data;
    logic         mem_wr_ack = 1'b0;
    logic         frame_ready;
    logic         frame_drop;
    logic [29:0]  frame_addr;
    logic [23:0]  frame_count;
    logic [1:0]   frame_slot;
    logic         overflow;

    frame_writer #(
        .BUF_BASE(BASE), .BUF_STRIDE(STRIDE), .NUM_BUFS(NB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_clk(reset_clk),
        .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .rd_busy(rd_busy), .rd_slot(rd_slot),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack),
        .frame_ready(frame_ready), .frame_drop(frame_drop),
        .frame_addr(frame_addr), .frame_count(frame_count), .frame_slot(frame_slot),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [28:0]  addr;
        logic [255:0] data;
    } wr_t;

    typedef struct {
        bit           drop;
        logic [29:0]  addr;
        logic [23:0]  count;
        logic [1:0]   slot;
    } fr_t;

    wr_t exp_wr[$];
    fr_t exp_fr[$];
    wr_t mon_w;
    fr_t mon_f;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  ack_mode = 0;
    int  last_slot = NB - 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       mem_wr_ack = 1'($urandom_range(0, 1));
                1:       mem_wr_ack = 1'b1;
                default: mem_wr_ack = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_clk) begin
                if (mem_wr_req && mem_wr_ack) begin
                    check("wr_expected", 256'(exp_wr.size() != 0), 256'(1));
                    if (exp_wr.size() != 0) begin
                        mon_w = exp_wr.pop_front();
                        check("wr_addr", 256'(mem_wr_addr), 256'(mon_w.addr));
                        check("wr_data", mem_wr_data, mon_w.data);
                    end
                end
                if (frame_ready || frame_drop) begin
                    check("frame_expected", 256'(exp_fr.size() != 0), 256'(1));
                    if (exp_fr.size() != 0) begin
                        mon_f = exp_fr.pop_front();
                        check("frame_kind", 256'({frame_ready, frame_drop}),
                              256'(mon_f.drop ? 2'b01 : 2'b10));
                        check("frame_addr", 256'(frame_addr), 256'(mon_f.addr));
                        check("frame_count", 256'(frame_count), 256'(mon_f.count));
                        check("frame_slot", 256'(frame_slot), 256'(mon_f.slot));
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset_clk = 1'b1;
        frame_start = 1'b0;
        frame_end = 1'b0;
        pix_valid = 1'b0;
        exp_wr.delete();
        exp_fr.delete();
        last_slot = NB - 1;
        repeat (2) @(posedge clk);
        #1;
        reset_clk = 1'b0;
    endtask

    // ackm: 0 random acks, 1 ack every cycle, 2 no acks until frame_end then every cycle
    task automatic run_frame(input int npix, input bit dense, input bit busy,
                             input logic [1:0] rslot, input int ackm, input bit ramp);
        logic [31:0]  pix[$];
        logic [255:0] d;
        logic [31:0]  base_b;
        wr_t          w;
        fr_t          f;
        int           slot, words, stored, i, bound, run;
        bit           sep;

        for (int p = 0; p < npix; p++) pix.push_back(ramp ? 32'(p) : $urandom);
        slot = (last_slot + 1) % NB;
        if (busy && slot == int'(rslot)) slot = (slot + 1) % NB;
        words  = (npix + 7) / 8;
        stored = (ackm == 2 && words > DEPTH) ? DEPTH : words;
        base_b = 32'(BASE) + 32'(slot) * 32'(STRIDE);
        for (int wi = 0; wi < stored; wi++) begin
            d = '0;
            for (int k = 0; k < 8; k++) begin
                if (8 * wi + k < npix) d[32 * k +: 32] = pix[8 * wi + k];
            end
            w.addr = 29'(base_b >> 1) + 29'(8 * wi);
            w.data = d;
            exp_wr.push_back(w);
        end
        f.drop  = (stored < words);
        f.addr  = 30'(base_b);
        f.count = 24'(32 * stored);
        f.slot  = 2'(slot);
        exp_fr.push_back(f);
        last_slot = slot;

        rd_busy  = busy;
        rd_slot  = rslot;
        ack_mode = ackm;
        sep      = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        i = 0;
        while (i < npix) begin
            pix_valid = dense || ($urandom_range(0, 2) != 0);
            if (pix_valid) begin
                pix_data = pix[i];
                i++;
            end
            frame_end = pix_valid && (i == npix) && !sep;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        if (sep) begin
            frame_end = 1'b1;
            @(posedge clk);
            #1;
        end
        frame_end = 1'b0;

        if (ackm == 2) begin
            ack_mode = 1;
            bound = 0;
            run = 0;
            while (!(mem_wr_req && mem_wr_ack) && bound < 50) begin
                @(negedge clk);
                bound++;
            end
            while (mem_wr_req && mem_wr_ack && bound < 200) begin
                run++;
                @(negedge clk);
                bound++;
            end
            check("b2b_run_length", 256'(run), 256'(stored));
        end

        bound = 0;
        while (exp_fr.size() != 0 && bound < 3000) begin
            @(negedge clk);
            bound++;
        end
        check("frame_done_in_time", 256'(exp_fr.size()), 256'(0));
        check("writes_drained", 256'(exp_wr.size()), 256'(0));
        exp_fr.delete();
        exp_wr.delete();
        rd_busy  = 1'b0;
        ack_mode = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_clk = 1'b0;
        @(negedge clk);
        check("rst_req", 256'(mem_wr_req), 256'(0));
        check("rst_addr", 256'(mem_wr_addr), 256'(0));
        check("rst_data", mem_wr_data, 256'(0));
        check("rst_ready_drop", 256'({frame_ready, frame_drop}), 256'(0));
        check("rst_frame_regs", 256'({frame_addr, frame_count, frame_slot}), 256'(0));
        check("rst_overflow", 256'(overflow), 256'(0));

        run_frame(16, 1'b1, 1'b0, 2'd0, 0, 1'b1);
        run_frame(10, 1'b1, 1'b0, 2'd0, 0, 1'b1);

        apply_reset();
        for (int n = 0; n < 3; n++) run_frame(8, 1'b1, 1'b0, 2'd0, 0, 1'b0);

        apply_reset();
        run_frame(8, 1'b1, 1'b0, 2'd0, 0, 1'b0);
        run_frame(8, 1'b1, 1'b1, 2'd1, 0, 1'b0);

        run_frame(17 * 8, 1'b1, 1'b0, 2'd0, 2, 1'b0);
        check("overflow_sticky", 256'(overflow), 256'(1));

        run_frame(64, 1'b1, 1'b0, 2'd0, 1, 1'b0);
        for (int n = 0; n < 10; n++) begin
            run_frame($urandom_range(1, 100), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, NB - 1)),
                      $urandom_range(0, 1), 1'b0);
        end
        check("overflow_still_set", 256'(overflow), 256'(1));

        apply_reset();
        ack_mode = 2;
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        for (int p = 0; p < 24; p++) begin
            pix_valid = 1'b1;
            pix_data  = $urandom;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
        check("req_before_reset", 256'(mem_wr_req), 256'(1));
        #2;
        reset_clk = 1'b1;
        exp_wr.delete();
        exp_fr.delete();
        last_slot = NB - 1;
        #1;
        check("req_at_reset", 256'(mem_wr_req), 256'(0));
        check("no_pulse_at_reset", 256'({frame_ready, frame_drop}), 256'(0));
        check("overflow_cleared", 256'(overflow), 256'(0));
        ack_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_clk = 1'b0;
        run_frame(16, 1'b1, 1'b0, 2'd0, 1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_writer.md
# frame_writer

Upstream stage of the DDR readout path: accepts the 32-bit pixel stream from the image sensor interface, packs it into 256-bit words, writes them into one of a ring of DDR frame slots through the MIG write port, and announces each completed frame (byte address and byte count) for the readout logic. Its `frame_ready`, `frame_addr` and `frame_count` outputs drive the readout start, address and count inputs of the DDR-to-PipeOut reader. Slot selection never targets the slot currently being read out.

## Interface
Parameters:
- BUF_BASE, 30'h0000000, byte address of slot 0
- BUF_STRIDE, 30'h0800000, slot size in bytes (8 MiB); multiple of 32, ≤ 2^23
- NUM_BUFS, 3, slot count, legal 3..4
- FIFO_DEPTH, 16, internal 256-bit word FIFO depth (power of 2)

Ports:
- clk  in  1  memory-interface clock; all logic single-domain
- reset_clk  in  1  reset, asynchronous, active-high
- frame_start  in  1  pulse, begins a frame
- frame_end  in  1  pulse, ends a frame; may coincide with the last pix_valid
- pix_valid  in  1  pixel word qualifier
- pix_data  in  32  pixel word
- rd_busy  in  1  readout in progress on rd_slot
- rd_slot  in  2  slot being read
- mem_wr_req  out  1  MIG write request
- mem_wr_addr  out  29  MIG word address (byte address >> 1)
- mem_wr_data  out  256  write data
- mem_wr_ack  in  1  request accepted
- frame_ready  out  1  one-cycle pulse, good frame stored
- frame_drop  out  1  one-cycle pulse, frame completed but corrupt
- frame_addr  out  30  byte address of the completed slot
- frame_count  out  24  bytes written (32 × words)
- frame_slot  out  2  slot index of the completed frame
- overflow  out  1  sticky; FIFO overrun or slot overrun since reset

## Operation
- States: IDLE, CAPTURE, FLUSH, DONE.
- IDLE, on frame_start:
  - Candidate slot = (last_slot + 1) mod NUM_BUFS.
  - If rd_busy and candidate == rd_slot, use candidate + 1 mod NUM_BUFS.
  - Word counter, pack index and bad flag are cleared.
  - Go to CAPTURE.
- CAPTURE:
  - Each pix_valid writes pix_data into lane k = pack index (bits 32k+31:32k); pack index increments.
  - At k = 7 the word is pushed to the FIFO.
  - frame_end goes to FLUSH; a pixel accepted in the same cycle is packed first.
  - A partial word (k ≠ 0) is pushed zero-padded.
- Overruns: a push while the FIFO is full, or a push beyond BUF_STRIDE/32 words, discards the word, sets bad and sets overflow.
- Address: the write unit pops the FIFO and presents the word with mem_wr_addr = (slot_base >> 1) + 8·n.
  - n = words written this frame.
  - slot_base = BUF_BASE + slot·BUF_STRIDE.
- FLUSH: waits until the FIFO is empty and no request is pending, then goes to DONE.
- DONE, one cycle:
  - Pulses frame_ready, or frame_drop if bad.
  - Updates frame_addr, frame_count, frame_slot and last_slot.
  - Returns to IDLE.
- Ignored events:
  - frame_start outside IDLE.
  - pix_valid or frame_end in IDLE.

## Timing
- Reset values:
  - All outputs 0; state IDLE; FIFO empty.
  - last_slot = NUM_BUFS−1, so the first frame lands in slot 0.
- Packing latency: the word is visible in the FIFO on the edge after the 8th accepted pixel.
- Write request:
  - mem_wr_req is registered and rises the cycle after the FIFO is non-empty.
  - Addr and data are stable while req is high.
  - When mem_wr_ack is sampled high, the next word is loaded on that edge and req stays high (back-to-back) if the FIFO has data; otherwise req falls.
  - A word counts as written only when it is acked.
- Frame completion:
  - frame_ready is emitted 1 cycle after the last ack, or 1 cycle after frame_end if nothing is pending.
  - frame_addr, frame_count and frame_slot are valid from the pulse cycle until the next DONE.
- Throughput: one pixel per cycle sustained if acks arrive at least once per 8 cycles.
- Reset mid-frame: everything is abandoned with no pulse; the pending request is dropped immediately.

## Test plan
- Reset, then frame_start, 16 pixels 0..15, frame_end:
  - 2 writes at mem_wr_addr 0 and 8.
  - Data lane 0 = 0 and 8 respectively.
  - frame_ready with frame_addr 0, frame_count 64, frame_slot 0.
- 10-pixel frame: second write carries pixels 8, 9 in lanes 0–1 with zero padding; frame_count 64.
- Three consecutive 8-pixel frames, rd_busy = 0:
  - Slots 0, 1, 2.
  - frame_addr 0, 0x800000, 0x1000000.
  - mem_wr_addr bases 0, 0x400000, 0x800000.
- rd_busy = 1, rd_slot = 1, after a frame in slot 0: next frame goes to slot 2.
- mem_wr_ack held low while 17 × 8 pixels stream: overflow = 1, frame_drop pulses instead of frame_ready, frame_count 512.
- Ack every cycle with a continuous pixel stream:
  - mem_wr_req stays high across back-to-back words.
  - Address sequence 0, 8, 16, …
  - Assert reset_clk mid-frame: req = 0 at once, no pulse; next frame_start targets slot 0.
